// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencing controller.
package game_pkg;

  typedef enum logic [2:0] {
    S_TITLE   = 3'd0,
    S_HOLD    = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSE   = 3'd3,
    S_RESPAWN = 3'd4,
    S_OVER    = 3'd5,
    S_WIN     = 3'd6
  } state_t;

  localparam int DEF_LIVES   = 3;
  localparam int DEF_WIN_POS = 1300;

  // Bits needed to hold values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_key_edge.sv
// Rising-edge detector for a key level; resets high so a key held through reset is not seen as a press.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or posedge rst)
    if (rst) prev <= 1'b1;
    else     prev <= level;

  assign rise = level & ~prev;

endmodule

// File: rtl/game_flow_ctrl.sv
// Game sequencing FSM: title, hold, play, pause, respawn, game-over and win screens with lives and enemy tracking.
module game_flow_ctrl import game_pkg::*; #(
  parameter int NUM_ENEMIES    = 2,
  parameter int POS_W          = 16,
  parameter int WIN_POS        = DEF_WIN_POS,
  parameter int LIVES          = DEF_LIVES,
  parameter int HOLD_CYCLES    = 2,
  parameter int RESPAWN_CYCLES = 60
) (
  input  logic                   Clk,
  input  logic                   reset,
  input  logic                   enter_on,
  input  logic                   pause_on,
  input  logic                   char_alive,
  input  logic [NUM_ENEMIES-1:0] enemy_die,
  input  logic [POS_W-1:0]       bg_position,
  output logic                   start_pic,
  output logic                   game_start,
  output logic                   begin_sig,
  output logic                   paused,
  output logic                   respawn,
  output logic                   dead_end,
  output logic                   win_end,
  output logic [3:0]             lives_left
);

  localparam int MAX_DUR = (HOLD_CYCLES > RESPAWN_CYCLES) ? HOLD_CYCLES : RESPAWN_CYCLES;
  localparam int CNT_W   = clog2(MAX_DUR + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESPAWN_CYCLES - 1);

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_ENEMIES-1:0] latch, latch_seen;
  logic [3:0]             lives, lives_nxt;
  logic                   enter_rise, pause_rise, win_cond;

  key_edge u_enter (.clk(Clk), .rst(reset), .level(enter_on), .rise(enter_rise));
  key_edge u_pause (.clk(Clk), .rst(reset), .level(pause_on), .rise(pause_rise));

  // Kills reported this cycle count toward the win immediately.
  assign latch_seen = latch | enemy_die;
  assign win_cond   = (&latch_seen) && (bg_position > POS_W'(WIN_POS));

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    case (state)
      S_TITLE: if (enter_rise) begin
        state_nxt = S_HOLD;
        lives_nxt = 4'(LIVES);
      end
      S_HOLD: if (cnt == HOLD_LAST) state_nxt = S_PLAY;
      S_PLAY: begin
        if (!char_alive) begin
          if (lives > 4'd1) begin
            lives_nxt = lives - 4'd1;
            state_nxt = S_RESPAWN;
          end else begin
            lives_nxt = 4'd0;
            state_nxt = S_OVER;
          end
        end else if (win_cond) begin
          state_nxt = S_WIN;
        end else if (pause_rise) begin
          state_nxt = S_PAUSE;
        end
      end
      S_PAUSE:        if (pause_rise)       state_nxt = S_PLAY;
      S_RESPAWN:      if (cnt == RESP_LAST) state_nxt = S_PLAY;
      S_OVER, S_WIN:  if (enter_rise)       state_nxt = S_TITLE;
      default:        state_nxt = S_TITLE;
    endcase
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state <= S_TITLE;
      cnt   <= '0;
      lives <= 4'(LIVES);
      latch <= '0;
    end else begin
      state <= state_nxt;
      lives <= lives_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 1'b1;
      if (state_nxt == S_HOLD && state != S_HOLD) latch <= '0;
      else if (state == S_PLAY)                   latch <= latch_seen;
    end
  end

  assign game_start = (state == S_HOLD);
  assign begin_sig  = (state == S_PLAY);
  assign paused     = (state == S_PAUSE);
  assign respawn    = (state == S_RESPAWN);
  assign dead_end   = (state == S_OVER);
  assign win_end    = (state == S_WIN);
  // Title also covers any illegal encoding so exactly one strobe stays high.
  assign start_pic  = ~(game_start | begin_sig | paused | respawn | dead_end | win_end);
  assign lives_left = lives;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed vector table, corner sequences, and randomized run against a reference model.
module tb_game_flow_ctrl;

  localparam int NE = 2, PW = 16, WP = 1300, LV = 3, HC = 2, RC = 60;

  localparam logic [6:0] T  = 7'b1000000, H = 7'b0100000, P = 7'b0010000, PA = 7'b0001000;
  localparam logic [6:0] R  = 7'b0000100, O = 7'b0000010, W = 7'b0000001;

  logic Clk = 1'b0;
  logic reset, enter_on, pause_on, char_alive;
  logic [NE-1:0] enemy_die;
  logic [PW-1:0] bg_position;
  logic start_pic, game_start, begin_sig, paused, respawn, dead_end, win_end;
  logic [3:0] lives_left;

  always #5 Clk = ~Clk;

  game_flow_ctrl #(
    .NUM_ENEMIES(NE), .POS_W(PW), .WIN_POS(WP), .LIVES(LV),
    .HOLD_CYCLES(HC), .RESPAWN_CYCLES(RC)
  ) dut (
    .Clk(Clk), .reset(reset), .enter_on(enter_on), .pause_on(pause_on),
    .char_alive(char_alive), .enemy_die(enemy_die), .bg_position(bg_position),
    .start_pic(start_pic), .game_start(game_start), .begin_sig(begin_sig),
    .paused(paused), .respawn(respawn), .dead_end(dead_end), .win_end(win_end),
    .lives_left(lives_left)
  );

  // Reference model: screen mode, cycles left in a timed screen, lives, set of killed enemies.
  typedef enum {M_TITLE, M_HOLD, M_PLAY, M_PAUSE, M_RESP, M_OVER, M_WIN} mode_t;
  mode_t   m_mode;
  int      m_left, m_lives;
  bit      m_pe, m_pp;
  bit [NE-1:0] m_dead;

  int passes = 0, checks = 0;

  task automatic model_reset();
    m_mode = M_TITLE; m_left = 0; m_lives = LV; m_pe = 1'b1; m_pp = 1'b1; m_dead = '0;
  endtask

  task automatic model_step();
    bit ee, pe;
    ee = enter_on && !m_pe;
    pe = pause_on && !m_pp;
    m_pe = enter_on;
    m_pp = pause_on;
    case (m_mode)
      M_TITLE: if (ee) begin m_mode = M_HOLD; m_left = HC; m_lives = LV; m_dead = '0; end
      M_HOLD:  begin m_left--; if (m_left == 0) m_mode = M_PLAY; end
      M_PLAY: begin
        m_dead |= enemy_die;
        if (!char_alive) begin
          if (m_lives > 1) begin m_lives--; m_mode = M_RESP; m_left = RC; end
          else begin m_lives = 0; m_mode = M_OVER; end
        end else if (m_dead == {NE{1'b1}} && int'(bg_position) > WP) m_mode = M_WIN;
        else if (pe) m_mode = M_PAUSE;
      end
      M_PAUSE: if (pe) m_mode = M_PLAY;
      M_RESP:  begin m_left--; if (m_left == 0) m_mode = M_PLAY; end
      default: if (ee) m_mode = M_TITLE;
    endcase
  endtask

  function automatic logic [10:0] exp_model();
    logic [6:0] s;
    s = 7'b1000000 >> int'(m_mode);
    return {s, 4'(m_lives)};
  endfunction

  function automatic logic [10:0] act();
    return {start_pic, game_start, begin_sig, paused, respawn, dead_end, win_end, lives_left};
  endfunction

  task automatic chk(input string name, input logic [10:0] exp);
    checks++;
    if (act() === exp) passes++;
    else $display("FAIL %s: got strobes/lives %b_%0d, expected %b_%0d",
                  name, act()[10:4], act()[3:0], exp[10:4], exp[3:0]);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Drive at negedge, step model with the clock, settle to the next negedge.
  task automatic apply(input logic e, input logic p, input logic a,
                       input logic [NE-1:0] en, input logic [PW-1:0] bg);
    enter_on = e; pause_on = p; char_alive = a; enemy_die = en; bg_position = bg;
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  typedef struct {
    logic e, p, a;
    logic [NE-1:0] en;
    logic [PW-1:0] bg;
    logic [6:0] st;
    logic [3:0] lv;
  } vec_t;

  vec_t tbl[17];

  task automatic row(input int i, input logic e, input logic p, input logic a,
                     input logic [NE-1:0] en, input logic [PW-1:0] bg,
                     input logic [6:0] st, input logic [3:0] lv);
    tbl[i] = '{e: e, p: p, a: a, en: en, bg: bg, st: st, lv: lv};
  endtask

  task automatic new_game();
    int n;
    apply(1, 0, 1, '0, '0);
    chk("newgame_hold", {H, 4'(LV)});
    n = 1;
    while (game_start && n < 20) begin
      apply(0, 0, 1, '0, '0);
      if (game_start) n++;
    end
    chk_int("hold_len", n, HC);
    chk("newgame_play", exp_model());
  endtask

  task automatic wait_respawn(input string name, input logic a);
    int n;
    n = 1;
    while (respawn && n < 200) begin
      apply(0, 0, a, '0, '0);
      if (respawn) n++;
    end
    chk_int(name, n, RC);
    chk({name, "_play"}, exp_model());
  endtask

  initial begin
    reset = 1'b1; enter_on = 1'b1; pause_on = 1'b0; char_alive = 1'b1;
    enemy_die = '0; bg_position = '0;
    model_reset();

    //       e  p  a  en     bg     st  lv
    row(0,  1, 0, 1, 2'b00, 0,    T,  3);
    row(1,  1, 0, 1, 2'b00, 0,    T,  3);
    row(2,  0, 0, 1, 2'b00, 0,    T,  3);
    row(3,  1, 0, 1, 2'b00, 0,    H,  3);
    row(4,  1, 0, 1, 2'b00, 0,    H,  3);
    row(5,  0, 0, 1, 2'b00, 0,    P,  3);
    row(6,  0, 1, 1, 2'b00, 0,    PA, 3);
    row(7,  0, 1, 0, 2'b11, 0,    PA, 3);
    row(8,  0, 0, 0, 2'b11, 0,    PA, 3);
    row(9,  0, 1, 1, 2'b00, 0,    P,  3);
    row(10, 0, 0, 1, 2'b00, 2000, P,  3);
    row(11, 0, 0, 1, 2'b01, 1300, P,  3);
    row(12, 0, 0, 1, 2'b00, 1300, P,  3);
    row(13, 0, 0, 1, 2'b10, 1300, P,  3);
    row(14, 0, 0, 1, 2'b00, 1301, W,  3);
    row(15, 1, 0, 1, 2'b00, 0,    T,  3);
    row(16, 0, 0, 1, 2'b00, 0,    T,  3);

    repeat (3) @(negedge Clk);
    chk("reset_state", {T, 4'(LV)});
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].e, tbl[i].p, tbl[i].a, tbl[i].en, tbl[i].bg);
      chk($sformatf("vec%0d", i), {tbl[i].st, tbl[i].lv});
    end

    // Three deaths: two respawns then game over; char_alive ignored during respawn.
    new_game();
    apply(0, 0, 0, '0, '0);
    chk("death1", {R, 4'd2});
    wait_respawn("respawn1_len", 1'b0);
    apply(0, 0, 0, '0, '0);
    chk("death2", {R, 4'd1});
    wait_respawn("respawn2_len", 1'b1);
    apply(0, 0, 1, 2'b01, '0);
    apply(0, 0, 1, 2'b10, '0);
    chk("latched_low_bg", {P, 4'd1});
    apply(0, 0, 0, 2'b11, 16'd2000);
    chk("death_beats_win", {O, 4'd0});
    apply(1, 0, 1, '0, '0);
    chk("over_to_title", {T, 4'd0});
    apply(0, 0, 1, '0, '0);

    // Death beats pause, then asynchronous reset mid-respawn.
    new_game();
    apply(0, 1, 0, '0, '0);
    chk("death_beats_pause", {R, 4'd2});
    apply(0, 0, 1, '0, '0);
    apply(0, 0, 1, '0, '0);
    reset = 1'b1;
    #1;
    chk("async_reset", {T, 4'(LV)});
    model_reset();
    enter_on = 1'b0; pause_on = 1'b0;
    @(negedge Clk);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      apply($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 39) != 0,
            {$urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0},
            (($urandom_range(0, 3) == 0) ? 16'd0 :
             ($urandom_range(0, 2) == 0) ? 16'd1300 :
             ($urandom_range(0, 1) == 0) ? 16'd1301 : 16'd2000));
      chk("rand", exp_model());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
